// File: rtl/arp_reply_tx.sv
// ARP reply framer: one request -> 42/60-byte Ethernet II ARP reply, first byte valid the cycle after launch.
// Byte held until data_ack_tx; one request can wait in pending while busy, further ones are dropped.
module arp_reply_tx #(
  parameter bit PAD_TO_MIN = 1'b1,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic [47:0] my_mac,
  input  logic [31:0] my_ip,
  input  logic        send_req,
  input  logic [47:0] req_mac,
  input  logic [31:0] req_ip,
  output logic        data_valid,
  output logic [7:0]  data_tx,
  input  logic        data_ack_tx,
  output logic        busy,
  output logic        frame_done,
  output logic        req_drop
);

  localparam int FRAME_LEN = PAD_TO_MIN ? 60 : 42;
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        state, state_nxt;
  logic          pend_vld;
  logic [47:0]   pend_mac;
  logic [31:0]   pend_ip;
  logic [47:0]   f_dmac, f_smac;
  logic [31:0]   f_sip, f_dip;
  logic [5:0]    idx;
  logic [GW-1:0] gap_cnt;
  logic          launch, last_ack;
  logic [47:0]   l_mac;
  logic [31:0]   l_ip;

  function automatic logic [7:0] frame_byte(input logic [5:0]  i,
                                            input logic [47:0] dmac,
                                            input logic [47:0] smac,
                                            input logic [31:0] sip,
                                            input logic [31:0] dip);
    logic [335:0] hdr;
    logic [8:0]   sel;
    hdr = {dmac, smac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
           smac, sip, dmac, dip};
    sel = 9'(8 * (41 - int'(i)));
    frame_byte = (i < 6'd42) ? hdr[sel +: 8] : 8'h00;
  endfunction

  // A held request always launches before a newly arriving one.
  assign launch   = (state == S_IDLE) && (pend_vld || send_req);
  assign last_ack = (state == S_SEND) && data_ack_tx && (idx == LAST_IDX);
  assign l_mac    = pend_vld ? pend_mac : req_mac;
  assign l_ip     = pend_vld ? pend_ip  : req_ip;
  assign busy     = (state != S_IDLE) || pend_vld;

  always_ff @(posedge clk) begin
    if (!areset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (launch) state_nxt = S_SEND;
      S_SEND: if (last_ack) state_nxt = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      pend_vld   <= 1'b0;
      pend_mac   <= '0;
      pend_ip    <= '0;
      f_dmac     <= '0;
      f_smac     <= '0;
      f_sip      <= '0;
      f_dip      <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      data_valid <= 1'b0;
      data_tx    <= 8'h00;
      frame_done <= 1'b0;
      req_drop   <= 1'b0;
    end else begin
      frame_done <= last_ack;
      req_drop   <= (state != S_IDLE) && send_req && pend_vld;

      if (state == S_IDLE && pend_vld) begin
        pend_vld <= send_req;
        if (send_req) begin
          pend_mac <= req_mac;
          pend_ip  <= req_ip;
        end
      end else if (state != S_IDLE && send_req && !pend_vld) begin
        pend_vld <= 1'b1;
        pend_mac <= req_mac;
        pend_ip  <= req_ip;
      end

      if (launch) begin
        f_dmac     <= l_mac;
        f_dip      <= l_ip;
        f_smac     <= my_mac;
        f_sip      <= my_ip;
        idx        <= '0;
        data_valid <= 1'b1;
        data_tx    <= frame_byte(6'd0, l_mac, my_mac, my_ip, l_ip);
      end else if (state == S_SEND && data_ack_tx) begin
        if (idx == LAST_IDX) begin
          data_valid <= 1'b0;
          data_tx    <= 8'h00;
        end else begin
          idx     <= idx + 6'd1;
          data_tx <= frame_byte(idx + 6'd1, f_dmac, f_smac, f_sip, f_dip);
        end
      end

      if (last_ack)                          gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed bench for arp_reply_tx: a padded/IFG=12 instance and an unpadded/IFG=0 instance.
module tb_arp_reply_tx;

  localparam logic [47:0] MY_MAC = 48'h02AABBCCDDEE;
  localparam logic [31:0] MY_IP  = 32'hC0A80001;
  localparam logic [31:0] NEW_IP = 32'h0A000001;
  localparam logic [47:0] A_MAC  = 48'h020000000001;
  localparam logic [31:0] A_IP   = 32'hC0A80002;
  localparam logic [47:0] B_MAC  = 48'h0400DEADBEEF;
  localparam logic [31:0] B_IP   = 32'hC0A80063;
  localparam logic [47:0] C_MAC  = 48'h06112233445F;
  localparam logic [31:0] C_IP   = 32'hC0A800FE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset_n, send_req, data_ack_tx, data_valid, busy, frame_done, req_drop;
  logic [47:0] my_mac, req_mac;
  logic [31:0] my_ip, req_ip;
  logic [7:0]  data_tx;

  logic        b_areset_n, b_send_req, b_data_ack_tx, b_data_valid, b_busy, b_frame_done, b_req_drop;
  logic [47:0] b_my_mac, b_req_mac;
  logic [31:0] b_my_ip, b_req_ip;
  logic [7:0]  b_data_tx;

  arp_reply_tx #(.PAD_TO_MIN(1'b1), .IFG_CYCLES(12)) dut (
    .clk(clk), .areset_n(areset_n), .my_mac(my_mac), .my_ip(my_ip),
    .send_req(send_req), .req_mac(req_mac), .req_ip(req_ip),
    .data_valid(data_valid), .data_tx(data_tx), .data_ack_tx(data_ack_tx),
    .busy(busy), .frame_done(frame_done), .req_drop(req_drop));

  arp_reply_tx #(.PAD_TO_MIN(1'b0), .IFG_CYCLES(0)) dut5 (
    .clk(clk), .areset_n(b_areset_n), .my_mac(b_my_mac), .my_ip(b_my_ip),
    .send_req(b_send_req), .req_mac(b_req_mac), .req_ip(b_req_ip),
    .data_valid(b_data_valid), .data_tx(b_data_tx), .data_ack_tx(b_data_ack_tx),
    .busy(b_busy), .frame_done(b_frame_done), .req_drop(b_req_drop));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  got[$];
  logic [7:0]  expq[$];
  int          inj_at[2];
  logic [47:0] inj_mac[2];
  logic [31:0] inj_ip[2];
  int          ip_chg_at, abort_at, drop_cnt;
  logic [31:0] ip_chg_val;
  int          n;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push48(input logic [47:0] v);
    logic [47:0] t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      expq.push_back(t[47:40]);
      t = t << 8;
    end
  endtask

  task automatic push32(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      expq.push_back(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic build_exp(input logic [47:0] dm, input logic [47:0] sm,
                           input logic [31:0] si, input logic [31:0] di, input int len);
    expq.delete();
    push48(dm);
    push48(sm);
    expq.push_back(8'h08); expq.push_back(8'h06);
    expq.push_back(8'h00); expq.push_back(8'h01);
    expq.push_back(8'h08); expq.push_back(8'h00);
    expq.push_back(8'h06); expq.push_back(8'h04);
    expq.push_back(8'h00); expq.push_back(8'h02);
    push48(sm);
    push32(si);
    push48(dm);
    push32(di);
    while (expq.size() < len) expq.push_back(8'h00);
  endtask

  task automatic compare_frame(input string tag);
    chki({tag, "_len"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk8($sformatf("%s_byte%0d", tag, i), got[i], expq[i]);
  endtask

  // Collects accepted bytes from the selected instance, starting at the current sample point.
  task automatic run_frame(input bit sel, input int len, input int mode);
    int         cyc;
    bit         unacked, chk_drop, ipd;
    bit         inj_done[2];
    logic [7:0] prev, d;
    logic       v, a;
    cyc = 0; unacked = 0; chk_drop = 0; ipd = 0; prev = 8'h00;
    inj_done[0] = 0; inj_done[1] = 0;
    got.delete();
    forever begin
      v = sel ? b_data_valid : data_valid;
      d = sel ? b_data_tx : data_tx;
      if (chk_drop) begin
        chk1("req_drop_after_C", req_drop, 1'b1);
        chk_drop = 0;
      end
      if (!sel && req_drop) drop_cnt++;
      if (unacked) begin
        chk1("hold_valid", v, 1'b1);
        chk8("hold_data", d, prev);
      end
      send_req = 1'b0;
      if (!inj_done[0] && inj_at[0] == got.size()) begin
        send_req = 1'b1; req_mac = inj_mac[0]; req_ip = inj_ip[0]; inj_done[0] = 1;
      end else if (!inj_done[1] && inj_at[1] == got.size()) begin
        send_req = 1'b1; req_mac = inj_mac[1]; req_ip = inj_ip[1]; inj_done[1] = 1;
        chk_drop = 1;
      end
      if (!ipd && ip_chg_at == got.size()) begin
        my_ip = ip_chg_val;
        ipd = 1;
      end
      a = (mode == 0) ? 1'b1 :
          ((cyc % 2 == 0) && !(cyc >= 9 && cyc < 14) && !(cyc >= 31 && cyc < 36));
      if (sel) b_data_ack_tx = a;
      else     data_ack_tx = a;
      if (v && a) begin
        got.push_back(d);
        unacked = 0;
      end else if (v) begin
        unacked = 1;
        prev = d;
      end
      if (abort_at >= 0 && got.size() == abort_at) begin
        areset_n = 1'b0;
        break;
      end
      if (got.size() == len) break;
      if (cyc >= 400) begin
        chki("frame_timeout", got.size(), len);
        break;
      end
      cyc++;
      step();
    end
  endtask

  task automatic wait_dv(input bit sel, output int cnt);
    cnt = 0;
    while (!(sel ? b_data_valid : data_valid) && cnt < 50) begin
      step();
      cnt++;
    end
  endtask

  task automatic launch_a(input logic [47:0] m, input logic [31:0] ip);
    req_mac = m; req_ip = ip; send_req = 1'b1;
    step();
    send_req = 1'b0;
  endtask

  initial begin
    areset_n = 1'b0; send_req = 1'b0; data_ack_tx = 1'b0;
    my_mac = MY_MAC; my_ip = MY_IP; req_mac = '0; req_ip = '0;
    b_areset_n = 1'b0; b_send_req = 1'b0; b_data_ack_tx = 1'b0;
    b_my_mac = MY_MAC; b_my_ip = MY_IP; b_req_mac = '0; b_req_ip = '0;
    inj_at[0] = -1; inj_at[1] = -1; ip_chg_at = -1; abort_at = -1; drop_cnt = 0;
    ip_chg_val = NEW_IP;
    inj_mac[0] = B_MAC; inj_ip[0] = B_IP; inj_mac[1] = C_MAC; inj_ip[1] = C_IP;
    repeat (3) step();
    chk1("rst_valid", data_valid, 1'b0);
    chk8("rst_data", data_tx, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", frame_done, 1'b0);
    chk1("rst_drop", req_drop, 1'b0);
    chk1("rst5_valid", b_data_valid, 1'b0);
    chk1("rst5_busy", b_busy, 1'b0);
    areset_n = 1'b1; b_areset_n = 1'b1;
    step();

    // T1: always-ack frame, then the 12-cycle gap
    launch_a(A_MAC, A_IP);
    chk1("t1_first_valid", data_valid, 1'b1);
    chk8("t1_first_byte", data_tx, 8'h02);
    run_frame(0, 60, 0);
    build_exp(A_MAC, MY_MAC, MY_IP, A_IP, 60);
    compare_frame("t1");
    if (got.size() == 60) begin
      chk8("t1_hand_b5", got[5], 8'h01);
      chk8("t1_hand_b7", got[7], 8'hAA);
      chk8("t1_hand_b12", got[12], 8'h08);
      chk8("t1_hand_b13", got[13], 8'h06);
      chk8("t1_hand_b21", got[21], 8'h02);
      chk8("t1_hand_b31", got[31], 8'h01);
      chk8("t1_hand_b41", got[41], 8'h02);
      chk8("t1_hand_b59", got[59], 8'h00);
    end
    step();
    chk1("t1_done", frame_done, 1'b1);
    chk1("t1_valid_after", data_valid, 1'b0);
    step();
    chk1("t1_done_once", frame_done, 1'b0);
    repeat (10) step();
    chk1("t1_gap_busy", busy, 1'b1);
    chk1("t1_gap_valid", data_valid, 1'b0);
    step();
    chk1("t1_idle_busy", busy, 1'b0);

    // T2: toggling ack with stall windows
    launch_a(A_MAC, A_IP);
    run_frame(0, 60, 1);
    compare_frame("t2");
    step();
    chk1("t2_done", frame_done, 1'b1);
    repeat (15) step();

    // T3: B queued at byte 10, C dropped at byte 20
    drop_cnt = 0;
    inj_at[0] = 10; inj_at[1] = 20;
    launch_a(A_MAC, A_IP);
    run_frame(0, 60, 0);
    inj_at[0] = -1; inj_at[1] = -1;
    compare_frame("t3_a");
    step();
    chk1("t3_a_done", frame_done, 1'b1);
    chk1("t3_busy_pending", busy, 1'b1);
    wait_dv(0, n);
    chki("t3_ifg_launch", n, 13);
    run_frame(0, 60, 0);
    build_exp(B_MAC, MY_MAC, MY_IP, B_IP, 60);
    compare_frame("t3_b");
    chki("t3_drop_count", drop_cnt, 1);
    step();
    chk1("t3_b_done", frame_done, 1'b1);
    repeat (20) step();
    chk1("t3_no_c_valid", data_valid, 1'b0);
    chk1("t3_no_c_busy", busy, 1'b0);

    // T4: reset at byte 30 with a request pending
    inj_at[0] = 10; abort_at = 30;
    launch_a(A_MAC, A_IP);
    run_frame(0, 60, 0);
    inj_at[0] = -1; abort_at = -1;
    chki("t4_partial", got.size(), 30);
    step();
    chk1("t4_rst_valid", data_valid, 1'b0);
    chk1("t4_rst_busy", busy, 1'b0);
    chk1("t4_rst_done", frame_done, 1'b0);
    chk8("t4_rst_data", data_tx, 8'h00);
    areset_n = 1'b1;
    repeat (20) step();
    chk1("t4_pend_cleared", data_valid, 1'b0);
    launch_a(C_MAC, C_IP);
    chk1("t4_fresh_valid", data_valid, 1'b1);
    run_frame(0, 60, 0);
    build_exp(C_MAC, MY_MAC, MY_IP, C_IP, 60);
    compare_frame("t4_fresh");
    step();
    chk1("t4_done", frame_done, 1'b1);
    repeat (15) step();

    // T6: my_ip changes mid-frame
    ip_chg_at = 20;
    launch_a(A_MAC, A_IP);
    run_frame(0, 60, 0);
    ip_chg_at = -1;
    build_exp(A_MAC, MY_MAC, MY_IP, A_IP, 60);
    compare_frame("t6_cur");
    step();
    repeat (14) step();
    chk1("t6_idle", busy, 1'b0);
    launch_a(B_MAC, B_IP);
    run_frame(0, 60, 0);
    build_exp(B_MAC, MY_MAC, NEW_IP, B_IP, 60);
    compare_frame("t6_next");
    step();

    // T5: unpadded, no gap, back-to-back requests
    b_req_mac = A_MAC; b_req_ip = A_IP; b_send_req = 1'b1;
    step();
    b_req_mac = B_MAC; b_req_ip = B_IP;
    step();
    b_send_req = 1'b0;
    run_frame(1, 42, 0);
    build_exp(A_MAC, MY_MAC, MY_IP, A_IP, 42);
    compare_frame("t5_1");
    step();
    chk1("t5_1_done", b_frame_done, 1'b1);
    chk1("t5_1_valid_low", b_data_valid, 1'b0);
    step();
    chk1("t5_2_valid", b_data_valid, 1'b1);
    run_frame(1, 42, 0);
    build_exp(B_MAC, MY_MAC, MY_IP, B_IP, 42);
    compare_frame("t5_2");
    step();
    chk1("t5_2_done", b_frame_done, 1'b1);
    chk1("t5_2_valid_low", b_data_valid, 1'b0);
    step();
    chk1("t5_idle", b_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
